// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU/link results and returned load data onto a
// single GPR write port, and keeps a per-register pending-load scoreboard for
// issue hazard detection.
//  - Loads are buffered in a 2-entry FIFO. ALU wins by default, but a starve
//    counter forces the FIFO through after three ALU wins in a row.
//  - The grant is registered, so a write shows up one cycle after its grant.
// Optional trace: define WB_ARB_TRACE_EN to log every registered write
// (class W) through the LOG macro. A plain fallback is provided if the core
// has not defined LOG.

`ifdef WB_ARB_TRACE_EN
`ifndef LOG
`define LOG(cls, msg) $display("[%s] %s", cls, msg)
`endif
`endif

module wb_arbiter (
  input  logic        _clk,
  input  logic        _reset,
  // ALU / link results
  input  logic        _alu_valid,
  input  logic [4:0]  _alu_rd,
  input  logic [31:0] _alu_data,
  output logic        _alu_ready,
  // returned load data
  input  logic        _mem_valid,
  input  logic [4:0]  _mem_rd,
  input  logic [31:0] _mem_data,
  output logic        _mem_ready,
  // issue / hazard
  input  logic        _iss_load,
  input  logic [4:0]  _iss_rd,
  input  logic [4:0]  _rs1,
  input  logic [4:0]  _rs2,
  output logic        _hazard,
  // GPR write port
  output logic        _wb_we,
  output logic [4:0]  _wb_rd,
  output logic [31:0] _wb_data,
  output logic [31:0] _pending
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [1:0] fifo_q, fifo_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic    fifo_full, fifo_ne;
  logic    grant_fifo, grant_alu, push;
  wb_ent_t head, gnt_ent;

  // Source selection, FIFO bookkeeping, starve counter and scoreboard update
  always_comb begin
    fifo_full  = (cnt_q == 2'd2);
    fifo_ne    = (cnt_q != 2'd0);
    head       = fifo_q[rd_ptr_q];

    // Nothing is granted or accepted while reset is held.
    grant_fifo = _reset & (fifo_full | ((starve_q == 2'd3) & fifo_ne) |
                           (~_alu_valid & fifo_ne));
    grant_alu  = _reset & ~grant_fifo & _alu_valid;
    _alu_ready = grant_alu;
    // Full means not ready even if a pop happens this cycle.
    _mem_ready = _reset & ~fifo_full;
    push       = _mem_valid & _mem_ready;

    gnt_ent    = grant_fifo ? head : wb_ent_t'{rd: _alu_rd, data: _alu_data};

    // A grant to x0 is consumed but never reaches the register file.
    wb_we_d    = (grant_fifo | grant_alu) & (gnt_ent.rd != 5'd0);
    wb_rd_d    = wb_we_d ? gnt_ent.rd   : 5'd0;
    wb_data_d  = wb_we_d ? gnt_ent.data : 32'd0;

    fifo_d     = fifo_q;
    if (push) fifo_d[wr_ptr_q] = wb_ent_t'{rd: _mem_rd, data: _mem_data};
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ grant_fifo;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, grant_fifo};

    // Counts consecutive ALU wins while a load is waiting.
    if (grant_fifo || !fifo_ne)            starve_d = 2'd0;
    else if (grant_alu && starve_q != 2'd3) starve_d = starve_q + 2'd1;
    else                                   starve_d = starve_q;

    // Clear first so a same-cycle re-issue of that rd leaves the bit set.
    pending_d = pending_q;
    if (grant_fifo) pending_d[head.rd] = 1'b0;
    if (_iss_load && _iss_rd != 5'd0) pending_d[_iss_rd] = 1'b1;
    pending_d[0] = 1'b0;

    _hazard = _reset & (pending_q[_rs1] | pending_q[_rs2] |
                        (_iss_load & pending_q[_iss_rd]));
  end

  // State registers; reset drops FIFO contents and any in-flight grant
  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      fifo_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      starve_q  <= 2'd0;
      pending_q <= 32'd0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign _wb_we   = wb_we_q;
  assign _wb_rd   = wb_rd_q;
  assign _wb_data = wb_data_q;
  assign _pending = pending_q;

`ifdef WB_ARB_TRACE_EN
  logic src_mem_q;

  // Remember which source produced the registered write, for the log only
  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) src_mem_q <= 1'b0;
    else         src_mem_q <= grant_fifo;
  end

  // Log the write presented during the cycle that just ended
  always @(posedge _clk) begin
    if (_reset) begin
      if (wb_we_q)
        `LOG("W", $sformatf("wb %s x%02d = %h", src_mem_q ? "mem" : "alu",
                            wb_rd_q, wb_data_q));
      else
        `LOG("W", "wb nop");
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors push expected GPR writes into a
// queue; a monitor on the falling edge pops and compares every write the DUT
// presents. Combinational handshake/hazard outputs are checked inline.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        iss_load;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        hazard;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t wq[$];
  int   errors = 0;
  int   checks = 0;

  wb_arbiter dut (
    ._clk(clk), ._reset(rst_n),
    ._alu_valid(alu_valid), ._alu_rd(alu_rd), ._alu_data(alu_data), ._alu_ready(alu_ready),
    ._mem_valid(mem_valid), ._mem_rd(mem_rd), ._mem_data(mem_data), ._mem_ready(mem_ready),
    ._iss_load(iss_load), ._iss_rd(iss_rd), ._rs1(rs1), ._rs2(rs2), ._hazard(hazard),
    ._wb_we(wb_we), ._wb_rd(wb_rd), ._wb_data(wb_data), ._pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    iss_load  = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd; e.data = d;
    wq.push_back(e);
  endtask

  // Monitor: every presented write must match the next expected one; idle
  // cycles must drive zero rd/data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (wb_we) begin
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got x%0d=%h expected no write", wb_rd, wb_data);
          end else begin
            e = wq.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data) begin
              errors++;
              $display("FAIL write: got x%0d=%h expected x%0d=%h", wb_rd, wb_data, e.rd, e.data);
            end
          end
        end else if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
          errors++;
          $display("FAIL idle_zero: got rd=%0d data=%h expected 0/0", wb_rd, wb_data);
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    alu(5'd5, 32'h1);                 // must not be granted during reset
    tick(); tick();
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_hazard",    {31'd0, hazard},    32'd0);
    chk("rst_pending",   pending,            32'd0);
    chk("rst_wb_we",     {31'd0, wb_we},     32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // Lone ALU write
    alu(5'd5, 32'h12345678);
    #1 chk("alu_ready_single", {31'd0, alu_ready}, 32'd1);
    expect_wr(5'd5, 32'h12345678);
    tick(); idle();

    // Load issue -> pending -> hazard -> return clears it
    iss_load = 1'b1; iss_rd = 5'd7;
    #1 chk("hazard_issue_cycle", {31'd0, hazard}, 32'd0);
    tick();
    iss_load = 1'b0; rs1 = 5'd7;
    #1 chk("pending7_set", {31'd0, pending[7]}, 32'd1);
    chk("hazard_rs1", {31'd0, hazard}, 32'd1);
    mem(5'd7, 32'hDEADBEEF);
    chk("mem_ready_empty", {31'd0, mem_ready}, 32'd1);
    tick();
    mem_valid = 1'b0;
    expect_wr(5'd7, 32'hDEADBEEF);    // granted this cycle, ALU idle
    tick();
    #1 chk("pending7_clear", {31'd0, pending[7]}, 32'd0);
    chk("hazard_drop", {31'd0, hazard}, 32'd0);
    idle();

    // Starvation: ALU wins 3 times, FIFO forced on the 4th
    mem(5'd9, 32'h0000A5A5);
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu(5'd11 + 5'(i), 32'h100 + 32'(i));
      #1 chk("starve_alu_ready", {31'd0, alu_ready}, 32'd1);
      expect_wr(5'd11 + 5'(i), 32'h100 + 32'(i));
      tick();
    end
    alu(5'd14, 32'h104);
    #1 chk("starve_forced_fifo", {31'd0, alu_ready}, 32'd0);
    expect_wr(5'd9, 32'h0000A5A5);
    tick();
    #1 chk("alu_after_fifo", {31'd0, alu_ready}, 32'd1);
    expect_wr(5'd14, 32'h104);
    tick(); idle();

    // FIFO fills with ALU busy; full forces FIFO grant; push+pop at count 1
    alu(5'd20, 32'h20); mem(5'd21, 32'h21);
    expect_wr(5'd20, 32'h20);
    tick();
    alu(5'd22, 32'h22); mem(5'd23, 32'h23);
    #1 chk("alu_beats_one_entry", {31'd0, alu_ready}, 32'd1);
    expect_wr(5'd22, 32'h22);
    tick();
    alu(5'd24, 32'h24); mem_valid = 1'b0;
    #1 chk("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("full_alu_stalled", {31'd0, alu_ready}, 32'd0);
    expect_wr(5'd21, 32'h21);
    tick();
    #1 chk("alu_after_full", {31'd0, alu_ready}, 32'd1);
    expect_wr(5'd24, 32'h24);
    tick();
    alu_valid = 1'b0; mem(5'd25, 32'h25);
    #1 chk("pushpop_mem_ready", {31'd0, mem_ready}, 32'd1);
    expect_wr(5'd23, 32'h23);
    tick();
    mem_valid = 1'b0;
    #1 chk("count_kept_one", {31'd0, mem_ready}, 32'd1);
    expect_wr(5'd25, 32'h25);
    tick(); idle();

    // Same-cycle clear and re-set of a pending bit keeps it set
    iss_load = 1'b1; iss_rd = 5'd3;
    tick();
    iss_load = 1'b0; mem(5'd3, 32'hC0FFEE03);
    tick();
    mem_valid = 1'b0; iss_load = 1'b1; iss_rd = 5'd3;
    #1 chk("hazard_iss_rd", {31'd0, hazard}, 32'd1);
    expect_wr(5'd3, 32'hC0FFEE03);
    tick();
    iss_load = 1'b0;
    #1 chk("pending3_reset_wins", {31'd0, pending[3]}, 32'd1);
    mem(5'd3, 32'h2);
    tick();
    mem_valid = 1'b0;
    expect_wr(5'd3, 32'h2);
    tick();
    #1 chk("pending3_clear", {31'd0, pending[3]}, 32'd0);
    idle();

    // ALU write to x0 is consumed without a GPR write
    alu(5'd0, 32'hFFFFFFFF);
    #1 chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick(); idle();
    #1 chk("x0_wb_we", {31'd0, wb_we}, 32'd0);
    tick();

    // Reset with two FIFO entries and a pending load
    alu(5'd30, 32'h30); mem(5'd26, 32'h26); iss_load = 1'b1; iss_rd = 5'd4;
    expect_wr(5'd30, 32'h30);
    tick();
    iss_load = 1'b0; alu(5'd0, 32'h0); mem(5'd27, 32'h27);
    #1 chk("pre_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    idle();
    rst_n = 1'b0;
    #1 chk("midrst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_wb_we", {31'd0, wb_we}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    alu(5'd1, 32'h1111);
    #1 chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    expect_wr(5'd1, 32'h1111);
    tick(); idle();
    tick(); tick(); tick();
    chk("post_rst_pending", pending, 32'd0);
    chk("queue_drained", 32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
